// File: rtl/uart_pkg.sv
// Shared types and constants for the UART TX arbiter and related UART blocks.
// Optional macro UART_TX_ARB_ID_HDR_EN adds the per-grant header-byte states.
package uart_pkg;

  localparam int UART_ARB_MAX_REQ = 8;
  localparam int UART_ARB_IDX_W   = $clog2(UART_ARB_MAX_REQ);
  localparam logic [3:0] UART_ARB_HDR_TAG = 4'hA;

`ifdef UART_TX_ARB_ID_HDR_EN
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    DATA_WAIT = 2'd1,
    HDR_WAIT  = 2'd2,
    DATA_LOAD = 2'd3
  } uart_arb_state_t;
`else
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    DATA_WAIT = 2'd1
  } uart_arb_state_t;
`endif

  // Header byte announcing which requester owns the following data byte.
  function automatic logic [7:0] uart_arb_hdr(input logic [UART_ARB_IDX_W-1:0] g);
    return {UART_ARB_HDR_TAG, 1'b0, g};
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational rotating-priority finder: first set bit of valid at or after ptr,
// wrapping modulo N. Shared by the TX arbiter and the RX fan-out block.
module rr_pick #(
  parameter int N = 4,
  localparam int W = $clog2(N)
) (
  input  logic [N-1:0] valid,
  input  logic [W-1:0] ptr,
  output logic         found,
  output logic [W-1:0] idx
);

  // Scan offsets from farthest to nearest so the nearest valid index wins.
  always_comb begin
    int sum;
    logic [W-1:0] cand;
    found = 1'b0;
    idx   = '0;
    sum   = 0;
    cand  = '0;
    for (int i = N - 1; i >= 0; i--) begin
      sum = int'(ptr) + i;
      if (sum >= N) begin
        sum = sum - N;
      end else begin
        sum = sum;
      end
      cand = W'(sum);
      if (valid[cand]) begin
        found = 1'b1;
        idx   = cand;
      end else begin
        found = found;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx serializer among NUM_REQ byte producers.
// Optional macro UART_TX_ARB_ID_HDR_EN prefixes each byte with a requester-id header.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic                 i_Clock,
  input  logic                 i_Rst_n,
  input  logic [NUM_REQ-1:0]   i_Req_Valid,
  input  logic [8*NUM_REQ-1:0] i_Req_Byte,
  output logic [NUM_REQ-1:0]   o_Req_Ready,
  output logic [NUM_REQ-1:0]   o_Grant,
  output logic                 o_Tx_DV,
  output logic [7:0]           o_Tx_Byte,
  input  logic                 i_Tx_Active,
  input  logic                 i_Tx_Done,
  output logic                 o_Busy
);

  localparam int ID_W = $clog2(NUM_REQ);

  uart_arb_state_t      state, state_n;
  logic [ID_W-1:0]      ptr, ptr_n;
  logic [NUM_REQ-1:0]   ready_n, grant_n;
  logic                 dv_n, busy_n;
  logic [7:0]           byte_n;
  logic                 pick_found;
  logic [ID_W-1:0]      pick_idx;
  logic [7:0]           pick_byte;
  logic                 ser_free;

  assign ser_free  = ~i_Tx_Active & ~i_Tx_Done;
  assign pick_byte = i_Req_Byte[{pick_idx, 3'b000} +: 8];

  rr_pick #(.N(NUM_REQ)) u_pick (
    .valid (i_Req_Valid),
    .ptr   (ptr),
    .found (pick_found),
    .idx   (pick_idx)
  );

`ifdef UART_TX_ARB_ID_HDR_EN
  logic [7:0] data_q, data_n;

  // Data byte parked while its header is on the wire.
  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      data_q <= 8'h00;
    end else begin
      data_q <= data_n;
    end
  end
`endif

  // Next-state and next-output logic; pulses default low every cycle.
  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    grant_n = o_Grant;
    ready_n = '0;
    dv_n    = 1'b0;
    byte_n  = o_Tx_Byte;
`ifdef UART_TX_ARB_ID_HDR_EN
    data_n  = data_q;
`endif
    case (state)
      IDLE: begin
        if (pick_found && ser_free) begin
          grant_n = NUM_REQ'(1) << pick_idx;
          ready_n = NUM_REQ'(1) << pick_idx;
          dv_n    = 1'b1;
          ptr_n   = (pick_idx == ID_W'(NUM_REQ - 1)) ? ID_W'(0) : pick_idx + ID_W'(1);
`ifdef UART_TX_ARB_ID_HDR_EN
          data_n  = pick_byte;
          byte_n  = uart_arb_hdr(UART_ARB_IDX_W'(pick_idx));
          state_n = HDR_WAIT;
`else
          byte_n  = pick_byte;
          state_n = DATA_WAIT;
`endif
        end else begin
          grant_n = '0;
          state_n = IDLE;
        end
      end
      DATA_WAIT: begin
        if (i_Tx_Done) begin
          grant_n = '0;
          state_n = IDLE;
        end else begin
          state_n = DATA_WAIT;
        end
      end
`ifdef UART_TX_ARB_ID_HDR_EN
      HDR_WAIT: begin
        if (i_Tx_Done) begin
          state_n = DATA_LOAD;
        end else begin
          state_n = HDR_WAIT;
        end
      end
      DATA_LOAD: begin
        if (ser_free) begin
          byte_n  = data_q;
          dv_n    = 1'b1;
          state_n = DATA_WAIT;
        end else begin
          state_n = DATA_LOAD;
        end
      end
`endif
      default: begin
        grant_n = '0;
        state_n = IDLE;
      end
    endcase
    busy_n = (state_n != IDLE);
  end

  // State, priority pointer and registered outputs.
  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state       <= IDLE;
      ptr         <= '0;
      o_Req_Ready <= '0;
      o_Grant     <= '0;
      o_Tx_DV     <= 1'b0;
      o_Tx_Byte   <= 8'h00;
      o_Busy      <= 1'b0;
    end else begin
      state       <= state_n;
      ptr         <= ptr_n;
      o_Req_Ready <= ready_n;
      o_Grant     <= grant_n;
      o_Tx_DV     <= dv_n;
      o_Tx_Byte   <= byte_n;
      o_Busy      <= busy_n;
    end
  end

endmodule
